// File: rtl/apb_master_if.sv
// Command/response port plus APB bus of the peripheral-bus initiator.
// The master modport is the initiator's view; slave is the view of whatever sits around it.
interface apb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Command side
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;
    logic [DATA_W/8-1:0]   cmd_strb;

    // Response side
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    // APB bus
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DATA_W/8-1:0]   pstrb;
    logic [DATA_W-1:0]     prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output paddr, pwdata, pwrite, psel, penable, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  paddr, pwdata, pwrite, psel, penable, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master.sv
// APB initiator: turns single-beat valid/ready commands into SETUP/ACCESS transfers,
// honours PREADY/PSLVERR and aborts transfers stalled longer than TIMEOUT cycles.
module apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic          clk,
    input  logic          rst,
    apb_master_if.master  bus
);

    localparam int STRB_W = DATA_W / 8;
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    wait_cnt_r;
    logic [ADDR_W-1:0]   paddr_r;
    logic [DATA_W-1:0]   pwdata_r;
    logic                pwrite_r;
    logic [STRB_W-1:0]   pstrb_r;
    logic                psel_r;
    logic                penable_r;
    logic                rsp_valid_r;
    logic [DATA_W-1:0]   rsp_rdata_r;
    logic                rsp_err_r;

    logic                cmd_ready_s;
    logic                accept_s;
    logic                timeout_hit_s;

    assign cmd_ready_s   = (state_r == IDLE);
    assign accept_s      = bus.cmd_valid & cmd_ready_s;
    assign timeout_hit_s = TIMEOUT_EN && (wait_cnt_r == TIMEOUT_M1);

    // Transfer FSM with registered bus and response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            wait_cnt_r  <= '0;
            paddr_r     <= '0;
            pwdata_r    <= '0;
            pwrite_r    <= 1'b0;
            pstrb_r     <= '0;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    penable_r <= 1'b0;
                    if (accept_s) begin
                        state_r    <= SETUP;
                        psel_r     <= 1'b1;
                        wait_cnt_r <= '0;
                        paddr_r    <= bus.cmd_addr;
                        pwdata_r   <= bus.cmd_wdata;
                        pwrite_r   <= bus.cmd_write;
                        // Reads never present strobes on the bus
                        pstrb_r    <= bus.cmd_write ? bus.cmd_strb : {STRB_W{1'b0}};
                    end else begin
                        psel_r <= 1'b0;
                    end
                end
                SETUP: begin
                    state_r   <= ACCESS;
                    psel_r    <= 1'b1;
                    penable_r <= 1'b1;
                end
                ACCESS: begin
                    if (bus.pready) begin
                        state_r     <= IDLE;
                        psel_r      <= 1'b0;
                        penable_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= bus.pslverr;
                        rsp_rdata_r <= (!pwrite_r && !bus.pslverr) ? bus.prdata : {DATA_W{1'b0}};
                    end else if (timeout_hit_s) begin
                        state_r     <= IDLE;
                        psel_r      <= 1'b0;
                        penable_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                        rsp_rdata_r <= '0;
                    end else if (wait_cnt_r != CNT_MAX) begin
                        wait_cnt_r <= wait_cnt_r + CNT_ONE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    psel_r    <= 1'b0;
                    penable_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_s;
    assign bus.paddr     = paddr_r;
    assign bus.pwdata    = pwdata_r;
    assign bus.pwrite    = pwrite_r;
    assign bus.pstrb     = pstrb_r;
    assign bus.psel      = psel_r;
    assign bus.penable   = penable_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: driver queues expected transfers, a slave model
// answers from the queue head, and a monitor checks bus fields and responses.
module tb_apb_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [3:0]  exp_pstrb;
        int          ws;
        bit          stuck;
        logic [31:0] prdata;
        logic        slverr;
        int          exp_psel;
        int          exp_pen;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } txn_t;

    txn_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [3:0] eps, input int ws,
                                input bit stuck, input logic [31:0] prd, input logic se,
                                input int epsel, input int epen, input logic eerr,
                                input logic [31:0] erd);
        txn_t t;
        t.w = w; t.addr = a; t.wdata = d; t.strb = s; t.exp_pstrb = eps;
        t.ws = ws; t.stuck = stuck; t.prdata = prd; t.slverr = se;
        t.exp_psel = epsel; t.exp_pen = epen; t.exp_err = eerr; t.exp_rdata = erd;
        return t;
    endfunction

    // Slave model: answers the transfer at the head of the queue
    initial begin
        int acc = 0;
        bus.pready  = 1'b0;
        bus.prdata  = 32'h0;
        bus.pslverr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.psel && bus.penable && q.size() > 0) begin
                bus.pready  = !q[0].stuck && (acc >= q[0].ws);
                bus.prdata  = q[0].prdata;
                bus.pslverr = bus.pready ? q[0].slverr : 1'b0;
                acc++;
            end else begin
                acc = 0;
                bus.pready  = 1'b0;
                bus.prdata  = 32'h0;
                bus.pslverr = 1'b0;
            end
        end
    end

    // Monitor: bus fields while selected, response against the scoreboard head
    initial begin
        int psel_cnt = 0;
        int pen_cnt  = 0;
        txn_t t;
        forever begin
            @(negedge clk);
            if (rst) begin
                psel_cnt = 0;
                pen_cnt  = 0;
            end else begin
                if (bus.psel) begin
                    psel_cnt++;
                    if (bus.penable) pen_cnt++;
                    if (q.size() == 0) begin
                        chk("psel_without_cmd", 64'd1, 64'd0);
                    end else begin
                        chk("cmd_ready_busy", {63'd0, bus.cmd_ready}, 64'd0);
                        chk("paddr", {32'd0, bus.paddr}, {32'd0, q[0].addr});
                        chk("pwrite", {63'd0, bus.pwrite}, {63'd0, q[0].w});
                        chk("pstrb", {60'd0, bus.pstrb}, {60'd0, q[0].exp_pstrb});
                        if (q[0].w) chk("pwdata", {32'd0, bus.pwdata}, {32'd0, q[0].wdata});
                    end
                end
                if (bus.rsp_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_rsp", 64'd1, 64'd0);
                    end else begin
                        t = q.pop_front();
                        chk("rsp_err", {63'd0, bus.rsp_err}, {63'd0, t.exp_err});
                        chk("rsp_rdata", {32'd0, bus.rsp_rdata}, {32'd0, t.exp_rdata});
                        chk("psel_cycles", 64'(psel_cnt), 64'(t.exp_psel));
                        chk("penable_cycles", 64'(pen_cnt), 64'(t.exp_pen));
                        chk("cmd_ready_at_rsp", {63'd0, bus.cmd_ready}, 64'd1);
                    end
                    psel_cnt = 0;
                    pen_cnt  = 0;
                end
            end
        end
    end

    task automatic send(input txn_t t, input bit hold, input bit b2b);
        int k;
        q.push_back(t);
        @(negedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = t.w;
        bus.cmd_addr  = t.addr;
        bus.cmd_wdata = t.wdata;
        bus.cmd_strb  = t.strb;
        k = 0;
        while (!bus.cmd_ready && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        if (!bus.cmd_ready) begin
            chk("cmd_accept_timeout", 64'd0, 64'd1);
            bus.cmd_valid = 1'b0;
            q.delete();
        end else begin
            if (b2b) chk("b2b_accept_in_rsp_cycle", {63'd0, bus.rsp_valid}, 64'd1);
            @(posedge clk); #1;
            if (!hold) bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (q.size() != 0 && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        if (q.size() != 0) begin
            chk("rsp_timeout", 64'd0, 64'd1);
            q.delete();
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_wdata = 32'h0;
        bus.cmd_strb  = 4'h0;
        #1;
        chk("rst_psel", {63'd0, bus.psel}, 64'd0);
        chk("rst_penable", {63'd0, bus.penable}, 64'd0);
        chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rst_paddr", {32'd0, bus.paddr}, 64'd0);
        chk("rst_pstrb", {60'd0, bus.pstrb}, 64'd0);
        chk("rst_rsp_rdata", {32'd0, bus.rsp_rdata}, 64'd0);
        chk("rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Zero-wait write; slave drives junk prdata that must not leak
        send(mk(1'b1, 32'h0, 32'h5F, 4'hF, 4'hF, 0, 1'b0, 32'hAAAA_5555, 1'b0, 2, 1, 1'b0, 32'h0), 1'b0, 1'b0);
        wait_idle();
        // Read with three wait states, strobes offered but not driven
        send(mk(1'b0, 32'h1, 32'h0, 4'hF, 4'h0, 3, 1'b0, 32'hF5, 1'b0, 5, 4, 1'b0, 32'hF5), 1'b0, 1'b0);
        wait_idle();
        @(negedge clk); #1;
        chk("rsp_valid_one_cycle", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rsp_rdata_hold", {32'd0, bus.rsp_rdata}, 64'hF5);
        // Slave error on read, then a normal read
        send(mk(1'b0, 32'h8, 32'h0, 4'h0, 4'h0, 0, 1'b0, 32'h1234, 1'b1, 2, 1, 1'b1, 32'h0), 1'b0, 1'b0);
        wait_idle();
        send(mk(1'b0, 32'hC, 32'h0, 4'h0, 4'h0, 1, 1'b0, 32'hA5, 1'b0, 3, 2, 1'b0, 32'hA5), 1'b0, 1'b0);
        wait_idle();
        // Slave error on a partial write
        send(mk(1'b1, 32'h4, 32'hCAFE_0001, 4'h3, 4'h3, 2, 1'b0, 32'h77, 1'b1, 4, 3, 1'b1, 32'h0), 1'b0, 1'b0);
        wait_idle();
        // Stuck slave: 16 ACCESS cycles then abort
        send(mk(1'b0, 32'h10, 32'h0, 4'h0, 4'h0, 0, 1'b1, 32'h99, 1'b0, 17, 16, 1'b1, 32'h0), 1'b0, 1'b0);
        wait_idle();
        @(negedge clk); #1;
        chk("rsp_err_hold", {63'd0, bus.rsp_err}, 64'd1);
        // Back-to-back with cmd_valid held high
        send(mk(1'b1, 32'h0, 32'h5F, 4'hF, 4'hF, 0, 1'b0, 32'h0, 1'b0, 2, 1, 1'b0, 32'h0), 1'b1, 1'b0);
        send(mk(1'b0, 32'h1, 32'h0, 4'hF, 4'h0, 0, 1'b0, 32'hF5, 1'b0, 2, 1, 1'b0, 32'hF5), 1'b0, 1'b1);
        wait_idle();

        // Reset in the middle of a stalled ACCESS
        send(mk(1'b0, 32'h20, 32'h0, 4'h0, 4'h0, 0, 1'b1, 32'h0, 1'b0, 0, 0, 1'b0, 32'h0), 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        chk("pre_rst_penable", {63'd0, bus.penable}, 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_psel", {63'd0, bus.psel}, 64'd0);
        chk("async_rst_penable", {63'd0, bus.penable}, 64'd0);
        chk("async_rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        q.delete();
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("post_rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
            chk("post_rst_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
        end
        send(mk(1'b0, 32'h24, 32'h0, 4'h0, 4'h0, 0, 1'b0, 32'h3C, 1'b0, 2, 1, 1'b0, 32'h3C), 1'b0, 1'b0);
        wait_idle();

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB master (initiator) that drives the peripheral bus carrying the UART and GPIO APB slaves.
- Converts single-beat commands from a simple valid/ready command port into APB setup/access transfers.
- Honours PREADY wait states and PSLVERR; aborts stalled transfers after a programmable timeout.
- Returns one response per command: read data plus error flag.

Parameters:
- ADDR_W, 32, width of cmd_addr and paddr
- DATA_W, 32, width of write/read data buses
- TIMEOUT, 16, max ACCESS cycles with pready low before abort; 0 disables timeout
- CNT_W, 16, width of wait-state counter; must hold TIMEOUT

Ports:
- clk  in  1  bus clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  master can accept a command
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- cmd_strb  in  DATA_W/8  byte strobes for writes
- rsp_valid  out  1  one-cycle pulse, transfer finished
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  pslverr seen or timeout
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pwrite  out  1  APB direction
- psel  out  1  APB select
- penable  out  1  APB enable
- pstrb  out  DATA_W/8  APB strobes
- prdata  in  DATA_W  slave read data
- pready  in  1  slave ready
- pslverr  in  1  slave error

Behaviour:
- Reset (async, immediate): state IDLE; psel, penable, pwrite, rsp_valid, rsp_err = 0; paddr, pwdata, pstrb, rsp_rdata = 0; wait counter = 0.
- Reset mid-transfer: bus released the same instant; no response is issued for the aborted command.
- cmd_ready = 1 only in IDLE, combinational from state.
- Handshake: command accepted on a rising edge with cmd_valid & cmd_ready.
  - cmd_* fields are registered into paddr, pwdata, pwrite, pstrb.
  - pstrb is forced to 0 for reads.
- FSM IDLE -> SETUP -> ACCESS -> IDLE:
  - IDLE: psel=0, penable=0. Accept moves to SETUP.
  - SETUP: exactly one cycle; psel=1, penable=0. Unconditionally moves to ACCESS.
  - ACCESS: psel=1, penable=1, counter increments each cycle pready=0.
    - pready=1 at an edge: transfer completes, go to IDLE.
    - TIMEOUT!=0 and counter==TIMEOUT-1 with pready=0: abort, go to IDLE.
- Address/data/control remain stable from SETUP through the last ACCESS cycle. They hold their values in IDLE; only psel/penable drop.
- Completion (edge where pready=1 in ACCESS):
  - Next cycle: rsp_valid=1 for exactly one cycle.
  - rsp_err = pslverr.
  - rsp_rdata = prdata if read and pslverr=0, else 0.
- Timeout abort: next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0; psel and penable drop the same cycle.
- Latency:
  - Accept at edge N gives SETUP during N..N+1 and ACCESS from N+1.
  - Zero-wait completion at edge N+2; rsp_valid high during cycle after N+2.
  - Minimum 3 cycles from accept to response.
- Back-to-back: cmd_ready is high in the same cycle rsp_valid pulses. The next command accepted there gives a new SETUP with no idle gap (sustained 1 transfer per 3 cycles).
- Wait counter clears on entry to SETUP. It saturates and does not wrap when TIMEOUT=0.
- rsp_rdata and rsp_err hold their last values after the rsp_valid pulse, until the next response.
- No response backpressure: the consumer must take rsp_valid when it pulses.

Test Plan:
- Zero-wait write: cmd addr=0x0, wdata=0x5F, strb=0xF, pready tied 1 -> psel 2 cycles, penable 1 cycle, pwdata=0x5F, pwrite=1, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: addr=0x1, slave holds pready=0 for 3 ACCESS cycles then returns prdata=0xF5 -> ACCESS lasts 4 cycles, paddr stable throughout, pstrb=0, rsp_rdata=0xF5, rsp_err=0.
- Slave error: read addr=0x8, pready=1 with pslverr=1 -> rsp_err=1, rsp_rdata=0, next command accepted normally.
- Timeout: TIMEOUT=16, pready stuck 0 -> exactly 16 ACCESS cycles, psel drops, rsp_valid with rsp_err=1, rsp_rdata=0.
- Back-to-back: write 0x5F to 0x0 then read 0x1, with cmd_valid held high -> second SETUP immediately follows first response cycle, responses in order.
- Async reset asserted mid-ACCESS -> psel/penable 0 without waiting for a clock edge, no rsp_valid, cmd_ready=1 after release.
